// File: rtl/music_pkg.sv
// Shared widths, rest code and state encoding
// for the ROM-driven melody sequencer.
package music_pkg;

   localparam int NOTE_W = 8;
   localparam int ADDR_W = 8;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY
   } seq_state_e;

endpackage

// File: rtl/music_step_timer.sv
// Counts the PLAY cycles of one melody step; terminal count marks
// the last PLAY cycle so FETCH+LOAD+PLAY spans CYCLES clocks.
module music_step_timer #(
   parameter int CYCLES = 10,
   parameter int W      = $clog2(CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [W-1:0] LAST = W'(CYCLES - 3);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Steps through a note ROM at STEP_HZ, feeding a tone generator
// with registered note/note_on plus strobe, playing and done flags.
module music_sequencer
   import music_pkg::*;
#(
   parameter int CLK_HZ  = 48000000,
   parameter int STEP_HZ = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0] rom_note,
   output logic [NOTE_W-1:0] note,
   output logic              note_on,
   output logic              step_strobe,
   output logic              playing,
   output logic              done
);

   localparam int STEP_CYCLES = CLK_HZ / STEP_HZ;

   if (STEP_CYCLES < 4) begin : g_bad_step
      $error("music_sequencer: STEP_CYCLES must be at least 4");
   end

   seq_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [NOTE_W-1:0] note_q;
   logic              note_on_q;
   logic              strobe_q;
   logic              playing_q;
   logic              done_q;
   logic [1:0]        rst_sync_q;
   logic              run_ok;
   logic              tmr_load;
   logic              tmr_en;
   logic              tmr_tc;

   // Reset release is synchronised; the FSM stays idle until it lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign run_ok   = rst_sync_q[1];
   assign tmr_load = (state_q == ST_LOAD);
   assign tmr_en   = (state_q == ST_PLAY) && !pause;

   music_step_timer #(
      .CYCLES (STEP_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tmr_load),
      .en_i   (tmr_en),
      .tc_o   (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         note_q    <= NOTE_REST;
         note_on_q <= 1'b0;
         strobe_q  <= 1'b0;
         playing_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         if (stop || !run_ok) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            note_q    <= NOTE_REST;
            note_on_q <= 1'b0;
            playing_q <= 1'b0;
         end else if (start) begin
            state_q   <= ST_FETCH;
            addr_q    <= '0;
            note_on_q <= (note_q != NOTE_REST) && !pause;
            playing_q <= 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  note_on_q <= 1'b0;
                  playing_q <= 1'b0;
               end
               ST_FETCH: begin
                  state_q   <= ST_LOAD;
                  note_on_q <= (note_q != NOTE_REST) && !pause;
                  playing_q <= 1'b1;
               end
               // LOAD always completes so the ROM read is never lost.
               ST_LOAD: begin
                  note_q   <= rom_note;
                  strobe_q <= 1'b1;
                  if (rom_note != NOTE_REST) begin
                     state_q   <= ST_PLAY;
                     note_on_q <= !pause;
                     playing_q <= 1'b1;
                  end else begin
                     note_on_q <= 1'b0;
                     done_q    <= 1'b1;
                     addr_q    <= '0;
                     state_q   <= loop_en ? ST_FETCH : ST_IDLE;
                     playing_q <= loop_en;
                  end
               end
               ST_PLAY: begin
                  note_on_q <= (note_q != NOTE_REST) && !pause;
                  playing_q <= 1'b1;
                  if (!pause && tmr_tc) begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= ST_FETCH;
                  end
               end
            endcase
         end
      end
   end

   assign rom_addr    = addr_q;
   assign note        = note_q;
   assign note_on     = note_on_q;
   assign step_strobe = strobe_q;
   assign playing     = playing_q;
   assign done        = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a 1-cycle ROM model
// and a strobe scoreboard of expected notes and step spacing.
module tb_music_sequencer;

   localparam int CLK_HZ  = 100;
   localparam int STEP_HZ = 10;

   typedef struct {
      int nt;
      int gap;
   } sb_t;

   typedef struct {
      int dly;
      bit start;
      bit pause;
      int addr;
      int nt;
      int on;
      int strb;
      int play;
      int dn;
   } vec_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic       pause   = 1'b0;
   logic       loop_en = 1'b0;
   logic [7:0] rom_addr;
   logic [7:0] rom_note = '0;
   logic [7:0] note;
   logic       note_on;
   logic       step_strobe;
   logic       playing;
   logic       done;

   logic [7:0] rom [256];

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int last_strb = 0;
   int done_cnt  = 0;
   sb_t sb[$];

   music_sequencer #(
      .CLK_HZ  (CLK_HZ),
      .STEP_HZ (STEP_HZ)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .loop_en     (loop_en),
      .rom_addr    (rom_addr),
      .rom_note    (rom_note),
      .note        (note),
      .note_on     (note_on),
      .step_strobe (step_strobe),
      .playing     (playing),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_note <= rom[rom_addr];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      sb_t e;
      @(negedge clk);
      cyc++;
      if (step_strobe) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_strobe", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("sb_note", int'(note), e.nt);
            if (e.gap != 0) chk("sb_gap", cyc - last_strb, e.gap);
         end
         last_strb = cyc;
      end
      if (done) done_cnt++;
   endtask

   task automatic go();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic rom_song();
      for (int i = 0; i < 256; i++) rom[i] = 8'd0;
      rom[0] = 8'd25;
      rom[1] = 8'd27;
      rom[2] = 8'd0;
   endtask

   initial begin
      vec_t tbl[12];
      int   lowc;
      int   act;
      bit   drop;
      bit   saw255;
      bit   wrapped;

      rom_song();
      step();
      step();
      chk("rst_addr", int'(rom_addr), 0);
      chk("rst_note", int'(note), 0);
      chk("rst_note_on", int'(note_on), 0);
      chk("rst_strobe", int'(step_strobe), 0);
      chk("rst_playing", int'(playing), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (3) step();

      // basic song, cycle-accurate table after the start pulse
      tbl[0]  = '{1, 1'b1, 1'b0, 0,  0, 0, 0, 1, 0};
      tbl[1]  = '{1, 1'b0, 1'b0, 0,  0, 0, 0, 1, 0};
      tbl[2]  = '{1, 1'b0, 1'b0, 0, 25, 1, 1, 1, 0};
      tbl[3]  = '{1, 1'b0, 1'b0, 0, 25, 1, 0, 1, 0};
      tbl[4]  = '{6, 1'b0, 1'b0, 0, 25, 1, 0, 1, 0};
      tbl[5]  = '{1, 1'b0, 1'b0, 1, 25, 1, 0, 1, 0};
      tbl[6]  = '{1, 1'b0, 1'b0, 1, 25, 1, 0, 1, 0};
      tbl[7]  = '{1, 1'b0, 1'b0, 1, 27, 1, 1, 1, 0};
      tbl[8]  = '{8, 1'b0, 1'b0, 2, 27, 1, 0, 1, 0};
      tbl[9]  = '{1, 1'b0, 1'b0, 2, 27, 1, 0, 1, 0};
      tbl[10] = '{1, 1'b0, 1'b0, 0,  0, 0, 1, 0, 1};
      tbl[11] = '{1, 1'b0, 1'b0, 0,  0, 0, 0, 0, 0};
      sb.push_back('{25, 0});
      sb.push_back('{27, 10});
      sb.push_back('{0, 10});
      done_cnt = 0;
      foreach (tbl[i]) begin
         start = tbl[i].start;
         pause = tbl[i].pause;
         step();
         start = 1'b0;
         repeat (tbl[i].dly - 1) step();
         chk("v_addr", int'(rom_addr), tbl[i].addr);
         chk("v_note", int'(note), tbl[i].nt);
         chk("v_note_on", int'(note_on), tbl[i].on);
         chk("v_strobe", int'(step_strobe), tbl[i].strb);
         chk("v_playing", int'(playing), tbl[i].play);
         chk("v_done", int'(done), tbl[i].dn);
      end
      chk("song_done_count", done_cnt, 1);
      chk("song_sb_left", sb.size(), 0);

      // looping playback
      loop_en = 1'b1;
      sb.push_back('{25, 0});
      sb.push_back('{27, 10});
      sb.push_back('{0, 10});
      sb.push_back('{25, 2});
      sb.push_back('{27, 10});
      sb.push_back('{0, 10});
      sb.push_back('{25, 2});
      done_cnt = 0;
      drop = 1'b0;
      go();
      for (int i = 1; i < 50; i++) begin
         if (!playing) drop = 1'b1;
         step();
      end
      if (!playing) drop = 1'b1;
      chk("loop_playing_drop", int'(drop), 0);
      chk("loop_done_count", done_cnt, 2);
      chk("loop_sb_left", sb.size(), 0);
      halt();
      loop_en = 1'b0;
      chk("loop_stop_playing", int'(playing), 0);
      chk("loop_stop_note", int'(note), 0);
      repeat (3) step();
      chk("loop_stop_no_done", done_cnt, 2);

      // no end marker: address wraps 255 -> 0
      for (int i = 0; i < 256; i++) rom[i] = 8'd30;
      sb.push_back('{30, 0});
      for (int i = 1; i < 260; i++) sb.push_back('{30, 10});
      done_cnt = 0;
      lowc = 0;
      saw255 = 1'b0;
      wrapped = 1'b0;
      go();
      for (int t = 2; t <= 2600; t++) begin
         step();
         if (t >= 3 && !note_on) lowc++;
         if (rom_addr == 8'd255) saw255 = 1'b1;
         if (saw255 && rom_addr == 8'd0 && playing) wrapped = 1'b1;
      end
      chk("wrap_seen", int'(wrapped), 1);
      chk("wrap_no_done", done_cnt, 0);
      chk("wrap_note_on_low", lowc, 0);
      chk("wrap_sb_left", sb.size(), 0);
      halt();

      // pause for 7 cycles in the middle of the first step
      rom_song();
      sb.push_back('{25, 0});
      sb.push_back('{27, 17});
      sb.push_back('{0, 10});
      done_cnt = 0;
      lowc = 0;
      go();
      repeat (4) step();
      pause = 1'b1;
      repeat (7) begin
         step();
         if (!note_on) lowc++;
      end
      pause = 1'b0;
      chk("pause_note_held", int'(note), 25);
      repeat (7) begin
         step();
         if (!note_on) lowc++;
      end
      chk("pause_low_cycles", lowc, 7);
      repeat (13) step();
      chk("pause_done_count", done_cnt, 1);
      chk("pause_sb_left", sb.size(), 0);
      chk("pause_idle", int'(playing), 0);

      // restart while playing, then start+stop together
      sb.push_back('{25, 0});
      sb.push_back('{25, 5});
      done_cnt = 0;
      go();
      repeat (4) step();
      go();
      chk("restart_addr", int'(rom_addr), 0);
      chk("restart_playing", int'(playing), 1);
      chk("restart_note_held", int'(note), 25);
      repeat (4) step();
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      chk("ss_playing", int'(playing), 0);
      chk("ss_note", int'(note), 0);
      chk("ss_note_on", int'(note_on), 0);
      chk("ss_addr", int'(rom_addr), 0);
      chk("ss_done", int'(done), 0);
      repeat (15) step();
      chk("ss_no_done", done_cnt, 0);
      chk("ss_sb_left", sb.size(), 0);

      // asynchronous reset in the middle of PLAY
      sb.push_back('{25, 0});
      go();
      repeat (4) step();
      chk("pre_rst_note", int'(note), 25);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_note", int'(note), 0);
      chk("arst_note_on", int'(note_on), 0);
      chk("arst_playing", int'(playing), 0);
      chk("arst_addr", int'(rom_addr), 0);
      sb.delete();
      done_cnt = 0;
      step();
      rst_n = 1'b1;
      act = 0;
      repeat (20) begin
         step();
         if (playing || step_strobe || rom_addr != 8'd0) act++;
      end
      chk("arst_idle_activity", act, 0);
      chk("arst_no_done", done_cnt, 0);
      sb.push_back('{25, 0});
      go();
      repeat (4) step();
      chk("arst_restart_note", int'(note), 25);
      chk("arst_restart_sb", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 48000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 8, meaning melody steps per second.
REQ-003 SHALL derive STEP_CYCLES = CLK_HZ/STEP_HZ (integer); elaboration SHALL fail if STEP_CYCLES < 4.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begin playback from address 0.
REQ-007 stop  input  1  one-cycle pulse; abort playback.
REQ-008 pause  input  1  level; freeze playback position while high.
REQ-009 loop_en  input  1  level; restart at address 0 on end-of-song.
REQ-010 rom_addr  output  8  registered address to the note ROM.
REQ-011 rom_note  input  8  ROM data, valid one cycle after rom_addr.
REQ-012 note  output  8  current note code to the tone generator; 0 = silence.
REQ-013 note_on  output  1  high while a nonzero note sounds.
REQ-014 step_strobe  output  1  one-cycle pulse when note is updated.
REQ-015 playing  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on end-of-song.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, LOAD, PLAY.
REQ-018 IDLE: rom_addr=0, note=0, note_on=0; start -> FETCH with rom_addr=0.
REQ-019 FETCH: SHALL last exactly one cycle, rom_addr stable, then -> LOAD.
REQ-020 LOAD: on exit edge SHALL register note<=rom_note, pulse step_strobe, and set note_on = (rom_note != 0).
REQ-021 LOAD with rom_note != 0 -> PLAY, step counter cleared.
REQ-022 LOAD with rom_note == 0 (end marker): note<=0, note_on<=0, done pulsed; loop_en=1 -> FETCH with rom_addr=0; loop_en=0 -> IDLE.
REQ-023 PLAY: SHALL last STEP_CYCLES-2 cycles, then rom_addr<=rom_addr+1 and -> FETCH, so consecutive step_strobe pulses are exactly STEP_CYCLES apart.
REQ-024 note and note_on SHALL hold their values through FETCH/LOAD with no intermediate glitch.
REQ-025 rom_addr increment SHALL wrap 255 -> 0 modulo 256; no done is raised on wrap.
REQ-026 pause high: step counter and FSM frozen, note_on forced 0, note held; release resumes at the same counter value.
REQ-027 pause in FETCH or LOAD SHALL freeze the FSM after LOAD completes (ROM read not discarded).
REQ-028 stop in any state SHALL, on the next edge, enter IDLE with rom_addr=0, note=0, note_on=0, and no done pulse.
REQ-029 start while playing SHALL restart at FETCH, rom_addr=0; start and stop together: stop wins.
REQ-030 start during pause SHALL restart; pause remains effective after LOAD.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, rom_addr=0, note=0, note_on=0, step_strobe=0, done=0, counter=0.
REQ-032 rst_n deassertion SHALL be synchronised internally (two-flop release); first start accepted two cycles after release.
REQ-033 reset mid-playback SHALL discard position; playback resumes only on a new start.

Structure
REQ-034 shared package music_pkg SHALL hold NOTE_W=8, ADDR_W=8, NOTE_REST=0 and the sequencer state enum.
REQ-035 step counter SHALL be one sub-module music_step_timer (load, enable, terminal-count output, width $clog2(STEP_CYCLES)).
REQ-036 all outputs SHALL be registered; no combinational path from rom_note to outputs.

Verification (CLK_HZ=100, STEP_HZ=10 -> STEP_CYCLES=10; behavioural ROM model, 1-cycle latency)
REQ-037 ROM {25,27,0}, start -> note 25 then 27 with step_strobe 10 cycles apart, then note=0, done pulse, IDLE, playing=0.
REQ-038 same ROM, loop_en=1 -> sequence 25,27,25,27..., done pulsed once per pass, playing stays 1.
REQ-039 ROM all 30, no zero -> rom_addr wraps 255->0 with no done, note_on never drops.
REQ-040 pause held 7 cycles mid-step -> note_on=0 for those 7 cycles, next step_strobe delayed by exactly 7 cycles.
REQ-041 start and stop in same cycle during PLAY -> IDLE next edge, note=0, no done.
REQ-042 rst_n pulsed low mid-PLAY asynchronously -> outputs zero immediately, no activity until start.
